bincnt_sorter_pipe: RTL and testbench

Parametrised, pipelined N-bit unary bit sorter and population counter: the successor to the fixed 2-bit and 3-bit combinational sorters in the bincnt family. Each accepted input word passes through an N-layer odd-even transposition network, one registered layer per cycle. The block outputs the sorted (thermometer) word and its binary one-count. Valid/ready handshakes on both sides let it sit in a streaming datapath with backpressure.

---
 rtl/bincnt_sorter_pipe.sv | 98 +++++++++
 tb/tb_bincnt_sorter_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bincnt_sorter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bincnt_sorter_pipe
// Purpose  : Pipelined N-bit unary bit sorter and population counter.
//            Each accepted word passes through an N-layer odd-even
//            transposition network, one registered layer per cycle. The
//            output is the thermometer-coded word plus its one-count.
//            Valid/ready on both sides, with a single global advance enable.
// Revision : 1.0 - initial release
// ============================================================================
module bincnt_sorter_pipe #(
    parameter int N           = 8,
    parameter bit ONES_AT_MSB = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_x,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_y,
    output logic [$clog2(N+1)-1:0] out_count
);

    localparam int CW = $clog2(N+1);

    // One compare-exchange layer. Even layers pair (0,1),(2,3)...; odd layers
    // pair (1,2),(3,4)...; an unpaired edge bit passes through untouched.
    function automatic logic [N-1:0] f_layer(input logic [N-1:0] d, input int s);
        logic [N-1:0] q;
        q = d;
        for (int i = s % 2; i + 1 < N; i += 2) begin
            if (ONES_AT_MSB) begin
                q[i+1] = d[i] | d[i+1];
                q[i]   = d[i] & d[i+1];
            end else begin
                q[i]   = d[i] | d[i+1];
                q[i+1] = d[i] & d[i+1];
            end
        end
        return q;
    endfunction

    logic [N-1:0] r_data  [N];
    logic [N-1:0] r_valid;
    logic [N-1:0] w_next  [N];
    logic         w_en;
    logic [CW-1:0] w_count;

    // The whole pipe advances together: it may move whenever the last stage
    // is empty or being consumed this cycle.
    assign w_en      = !r_valid[N-1] || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_valid[N-1];
    assign out_y     = r_data[N-1];
    assign out_count = w_count;

    // Layer s computes its compare-exchange on the previous stage's register
    // (layer 0 works directly on the incoming word).
    generate
        for (genvar s = 0; s < N; s++) begin : g_stage
            if (s == 0) begin : g_first
                assign w_next[s] = f_layer(in_x, s);
            end else begin : g_rest
                assign w_next[s] = f_layer(r_data[s-1], s);
            end
        end
    endgenerate

    // Pipeline registers: clear on reset, shift forward together when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N; s++) begin
                r_data[s] <= '0;
            end
            r_valid <= '0;
        end else if (w_en) begin
            for (int s = 0; s < N; s++) begin
                r_data[s] <= w_next[s];
            end
            r_valid <= {r_valid[N-2:0], in_valid};
        end
    end

    // Count = position of the first zero scanning in from the packed end;
    // all ones gives N. Mirrored scan order when ones pack toward the MSB.
    always_comb begin
        w_count = CW'(N);
        for (int i = N - 1; i >= 0; i--) begin
            if (!out_y[ONES_AT_MSB ? (N - 1 - i) : i]) begin
                w_count = CW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bincnt_sorter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bincnt_sorter_pipe
// Purpose  : Scoreboard bench for bincnt_sorter_pipe, two configurations:
//            A = N=8 ones-at-LSB, B = N=3 ones-at-MSB.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bincnt_sorter_pipe;

    localparam int NA = 8;
    localparam int NB = 3;

    typedef struct {
        logic [63:0] y;
        int          c;
        int          t;
        int          snap;
    } exp_t;

    logic clk;
    logic rst_a, rst_b;

    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [NA-1:0] a_in_x, a_out_y;
    logic [3:0]    a_out_count;

    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [NB-1:0] b_in_x, b_out_y;
    logic [1:0]    b_out_count;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   sa     = 0;
    int   sb     = 0;
    logic pra = 1'b0, prb = 1'b0;
    logic a_prev_stall = 1'b0, b_prev_stall = 1'b0;
    logic [NA-1:0] a_hold_y;
    logic [3:0]    a_hold_c;
    logic [NB-1:0] b_hold_y;
    logic [1:0]    b_hold_c;

    bincnt_sorter_pipe #(.N(NA), .ONES_AT_MSB(1'b0)) u_a (
        .clk(clk), .rst(rst_a),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_x(a_in_x),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_y(a_out_y), .out_count(a_out_count)
    );

    bincnt_sorter_pipe #(.N(NB), .ONES_AT_MSB(1'b1)) u_b (
        .clk(clk), .rst(rst_b),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_in_x),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_y(b_out_y), .out_count(b_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        pra <= rst_a;
        prb <= rst_b;
    end

    // Reference: popcount, then a thermometer code packed toward the chosen end.
    function automatic exp_t model(input logic [63:0] x, input int n, input bit msb);
        exp_t e;
        int   c;
        c = 0;
        for (int i = 0; i < n; i++) c += int'(x[i]);
        e.y = (64'(1) << c) - 64'(1);
        if (msb) e.y = e.y << (n - c);
        e.c = c;
        e.t = 0;
        e.snap = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard for A.
    always @(negedge clk) begin
        exp_t e;
        if (rst_a) begin
            qa.delete();
            if (pra) begin
                chk("a_rst_in_ready", 64'(a_in_ready), 64'(1));
                chk("a_rst_out_valid", 64'(a_out_valid), 64'(0));
            end
        end else begin
            chk("a_in_ready_rule", 64'(a_in_ready), 64'(!a_out_valid || a_out_ready));
            if (pra) begin
                chk("a_post_rst_valid", 64'(a_out_valid), 64'(0));
                chk("a_post_rst_y", 64'(a_out_y), 64'(0));
                chk("a_post_rst_count", 64'(a_out_count), 64'(0));
            end
            if (a_prev_stall) begin
                chk("a_hold_y", 64'(a_out_y), 64'(a_hold_y));
                chk("a_hold_count", 64'(a_out_count), 64'(a_hold_c));
            end
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_spurious_output: got y=%0h with empty scoreboard, expected no output", a_out_y);
                end else begin
                    e = qa.pop_front();
                    chk("a_y", 64'(a_out_y), e.y);
                    chk("a_count", 64'(a_out_count), 64'(e.c));
                    chk("a_latency", 64'(cyc), 64'(e.t + NA - 1 + sa - e.snap));
                end
            end
            if (a_in_valid && a_in_ready) begin
                e = model(64'(a_in_x), NA, 1'b0);
                e.t = cyc + 1;
                e.snap = sa;
                qa.push_back(e);
            end
            if (a_out_valid && !a_out_ready) sa++;
        end
        a_prev_stall = !rst_a && a_out_valid && !a_out_ready;
        a_hold_y = a_out_y;
        a_hold_c = a_out_count;
    end

    // Monitor / scoreboard for B.
    always @(negedge clk) begin
        exp_t e;
        if (rst_b) begin
            qb.delete();
            if (prb) begin
                chk("b_rst_in_ready", 64'(b_in_ready), 64'(1));
                chk("b_rst_out_valid", 64'(b_out_valid), 64'(0));
            end
        end else begin
            chk("b_in_ready_rule", 64'(b_in_ready), 64'(!b_out_valid || b_out_ready));
            if (prb) begin
                chk("b_post_rst_valid", 64'(b_out_valid), 64'(0));
                chk("b_post_rst_y", 64'(b_out_y), 64'(0));
                chk("b_post_rst_count", 64'(b_out_count), 64'(0));
            end
            if (b_prev_stall) begin
                chk("b_hold_y", 64'(b_out_y), 64'(b_hold_y));
                chk("b_hold_count", 64'(b_out_count), 64'(b_hold_c));
            end
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_spurious_output: got y=%0h with empty scoreboard, expected no output", b_out_y);
                end else begin
                    e = qb.pop_front();
                    chk("b_y", 64'(b_out_y), e.y);
                    chk("b_count", 64'(b_out_count), 64'(e.c));
                    chk("b_latency", 64'(cyc), 64'(e.t + NB - 1 + sb - e.snap));
                end
            end
            if (b_in_valid && b_in_ready) begin
                e = model(64'(b_in_x), NB, 1'b1);
                e.t = cyc + 1;
                e.snap = sb;
                qb.push_back(e);
            end
            if (b_out_valid && !b_out_ready) sb++;
        end
        b_prev_stall = !rst_b && b_out_valid && !b_out_ready;
        b_hold_y = b_out_y;
        b_hold_c = b_out_count;
    end

    task automatic drive_a(input logic v, input logic [NA-1:0] x, input logic r);
        a_in_valid  = v;
        a_in_x      = x;
        a_out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic v, input logic [NB-1:0] x, input logic r);
        b_in_valid  = v;
        b_in_x      = x;
        b_out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic run_a();
        rst_a = 1'b1;
        repeat (2) drive_a(1'b1, 8'hA5, 1'b1);
        rst_a = 1'b0;
        repeat (2) drive_a(1'b0, 8'h00, 1'b1);
        // single word, then the two corners
        drive_a(1'b1, 8'b1010_0110, 1'b1);
        repeat (10) drive_a(1'b0, 8'h00, 1'b1);
        drive_a(1'b1, 8'h00, 1'b1);
        repeat (10) drive_a(1'b0, 8'h00, 1'b1);
        drive_a(1'b1, 8'hFF, 1'b1);
        repeat (10) drive_a(1'b0, 8'h00, 1'b1);
        // every value back to back
        for (int i = 0; i < 256; i++) drive_a(1'b1, 8'(i), 1'b1);
        repeat (10) drive_a(1'b0, 8'h00, 1'b1);
        // backpressure on a full pipe
        repeat (10) drive_a(1'b1, 8'($urandom), 1'b1);
        for (int i = 0; i < 5; i++) begin
            a_in_valid  = 1'b1;
            a_in_x      = 8'($urandom);
            a_out_ready = 1'b0;
            #2;
            chk("a_bp_in_ready", 64'(a_in_ready), 64'(0));
            @(posedge clk);
            #1;
        end
        repeat (10) drive_a(1'b1, 8'($urandom), 1'b1);
        repeat (10) drive_a(1'b0, 8'h00, 1'b1);
        // reset with words in flight
        repeat (3) drive_a(1'b1, 8'($urandom), 1'b1);
        repeat (2) drive_a(1'b0, 8'h00, 1'b1);
        rst_a = 1'b1;
        drive_a(1'b0, 8'h00, 1'b1);
        rst_a = 1'b0;
        drive_a(1'b1, 8'h3C, 1'b1);
        repeat (12) drive_a(1'b0, 8'h00, 1'b1);
        // random traffic with bubbles and backpressure
        for (int i = 0; i < 400; i++)
            drive_a(1'(($urandom % 10) < 7), 8'($urandom), 1'(($urandom % 10) < 7));
        repeat (12) drive_a(1'b0, 8'h00, 1'b1);
    endtask

    task automatic run_b();
        rst_b = 1'b1;
        repeat (2) drive_b(1'b1, 3'b101, 1'b1);
        rst_b = 1'b0;
        drive_b(1'b0, 3'b000, 1'b1);
        for (int i = 0; i < 8; i++) drive_b(1'b1, 3'(i), 1'b1);
        repeat (6) drive_b(1'b0, 3'b000, 1'b1);
        for (int i = 0; i < 200; i++)
            drive_b(1'(($urandom % 10) < 7), 3'($urandom), 1'(($urandom % 10) < 6));
        repeat (8) drive_b(1'b0, 3'b000, 1'b1);
    endtask

    initial begin
        rst_a = 1'b1; a_in_valid = 1'b0; a_in_x = '0; a_out_ready = 1'b1;
        rst_b = 1'b1; b_in_valid = 1'b0; b_in_x = '0; b_out_ready = 1'b1;
        fork
            run_a();
            run_b();
        join
        @(negedge clk);
        chk("a_drained", 64'(qa.size()), 64'(0));
        chk("b_drained", 64'(qb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
